gpio_seq: RTL and testbench
===========================

GPIO_SEQ -- requirements
Module: gpio_seq

Interface
REQ-001 Parameter LGFIFO, default 3, log2 of command FIFO depth (8 entries).
REQ-002 Parameter TMO_CYCLES, default 16, master-port ack timeout in cycles (used only with GPIO_SEQ_TIMEOUT_EN).
REQ-003 i_clk  in  1  sole clock; all logic on rising edge.
REQ-004 i_reset  in  1  reset, asynchronous, active-high.
REQ-005 i_wb_cyc, i_wb_stb, i_wb_we  in  1 each  slave Wishbone strobes.
REQ-006 i_wb_addr  in  2  register select: 0 CTRL, 1 DELAY, 2 PUSH, 3 reserved.
REQ-007 i_wb_data  in  32  slave write data; i_wb_sel  in  4  ignored.
REQ-008 o_wb_stall  out  1  constant 0; o_wb_ack  out  1; o_wb_data  out  32.
REQ-009 o_gpio_cyc, o_gpio_stb, o_gpio_we  out  1 each  master port to GPIO controller; o_gpio_we constant 1.
REQ-010 o_gpio_data  out  32  GPIO write word (upper 16 = mask, lower 16 = value).
REQ-011 i_gpio_ack, i_gpio_stall  in  1 each  master-port response.
REQ-012 o_int  out  1  level interrupt = DONE | ERR.

Function
REQ-013 Slave: o_wb_ack SHALL assert exactly one cycle after any cycle with i_wb_stb, for reads and writes.
REQ-014 Read data SHALL be registered with ack; CTRL read = {18'b0, EMPTY[13], FULL[12], FILL[11:8], 3'b0, OVF[4], ERR[3], DONE[2], BUSY[1], RUN[0]}; DELAY read = {16'b0, DELAY}; PUSH/reserved read 0.
REQ-015 CTRL write: bit0 sets RUN; bit1 FLUSH empties FIFO (self-clearing, does not abort in-flight command); bit2 clears DONE, ERR, OVF.
REQ-016 DELAY write latches i_wb_data[15:0]; value persists and applies to every subsequent PUSH.
REQ-017 PUSH write enqueues {DELAY, i_wb_data}; when FULL the write is dropped and OVF set; FIFO unchanged.
REQ-018 Simultaneous PUSH and pop in one cycle SHALL both take effect; FILL unchanged, no OVF even when FULL.
REQ-019 FSM states IDLE, WAIT, BUS; BUSY = state != IDLE.
REQ-020 IDLE->WAIT when RUN and not EMPTY: entry popped, counter loaded with its delay D.
REQ-021 WAIT: counter==0 -> BUS, else decrement; first o_gpio_stb SHALL appear D+1 cycles after the pop edge.
REQ-022 BUS: o_gpio_cyc and o_gpio_stb asserted with o_gpio_data = entry word; stb drops the cycle after stb && !i_gpio_stall; cyc held until i_gpio_ack, then IDLE.
REQ-023 Acks with cyc low SHALL be ignored; ack concurrent with un-stalled stb SHALL complete the transaction in that cycle.
REQ-024 RUN cleared (CTRL write bit0=0) mid-command: current command completes through BUS; no further pops.
REQ-025 DONE SHALL set on return to IDLE when FIFO EMPTY and at least one command executed since last DONE clear.
REQ-026 FIFO pointers LGFIFO bits wrapping modulo depth; FILL is LGFIFO+1 bits, FULL at FILL==2^LGFIFO.

Reset
REQ-027 On i_reset: state IDLE, FIFO empty, RUN/DONE/ERR/OVF 0, DELAY 0, counter 0, o_wb_ack 0, o_wb_data 0, o_gpio_cyc/stb 0, o_gpio_data 0, o_int 0.
REQ-028 Reset during BUS SHALL drop o_gpio_cyc/stb immediately (asynchronously), abandoning the transaction.

Configuration
REQ-029 Macro GPIO_SEQ_TIMEOUT_EN defined: in BUS, TMO_CYCLES consecutive cycles with cyc and no ack SHALL drop cyc/stb, set ERR, clear RUN, return IDLE; FIFO contents retained.
REQ-030 Macro undefined: BUS waits indefinitely for ack; ERR reads constant 0; no timeout counter present.

Verification
REQ-031 DELAY=5, PUSH 0x0001_0001, RUN=1 -> o_gpio_stb with data 0x00010001 exactly 6 cycles after pop; DONE=1, o_int=1 after ack.
REQ-032 Push 9 entries with LGFIFO=3, RUN=0 -> FILL=8, FULL=1, OVF=1; 9th word absent when drained.
REQ-033 i_gpio_stall high 3 cycles in BUS -> stb held 4 cycles, single write, cyc held until ack.
REQ-034 RUN cleared during WAIT with 3 entries queued -> in-flight write completes, FILL=2, BUSY=0, DONE=0.
REQ-035 GPIO_SEQ_TIMEOUT_EN, ack never returned -> cyc drops after 16 cycles, ERR=1, RUN=0, o_int=1; CTRL bit2 write clears o_int.
REQ-036 i_reset asserted mid-BUS -> cyc/stb low same cycle, EMPTY=1, all CTRL bits 0.

Source files
------------

// File: rtl/gpio_seq_if.sv
// +----------------------------------------------------------------------+
// | gpio_seq_if : Wishbone-style bus bundle, used as a slave and master.  |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
`default_nettype none

interface gpio_seq_if #(
  parameter int AW = 2
) ();
  logic          cyc;
  logic          stb;
  logic          we;
  logic [AW-1:0] addr;
  logic [31:0]   wdata;
  logic [3:0]    sel;
  logic          ack;
  logic          stall;
  logic [31:0]   rdata;

  modport master (
    output cyc, stb, we, addr, wdata, sel,
    input  ack, stall, rdata
  );

  modport slave (
    input  cyc, stb, we, addr, wdata, sel,
    output ack, stall, rdata
  );
endinterface

`default_nettype wire

// File: rtl/gpio_seq.sv
// +----------------------------------------------------------------------+
// | gpio_seq : timed GPIO write sequencer fed by a command FIFO.          |
// | Optional bus timeout with macro GPIO_SEQ_TIMEOUT_EN.  Revision 1.0    |
// +----------------------------------------------------------------------+
`default_nettype none

module gpio_seq #(
  parameter int LGFIFO     = 3,
  parameter int TMO_CYCLES = 16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  gpio_seq_if.slave   wb,
  gpio_seq_if.master  gpio,
  output logic        o_int
);

  localparam int DEPTH = 1 << LGFIFO;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    BUS  = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;

  logic [47:0]       mem [DEPTH];
  logic [LGFIFO-1:0] wr_ptr;
  logic [LGFIFO-1:0] rd_ptr;
  logic [LGFIFO:0]   fill;
  logic [3:0]        fill4;
  logic              empty;
  logic              full;
  logic [47:0]       head;

  logic              run;
  logic              done;
  logic              ovf;
  logic              err;
  logic              busy;
  logic [15:0]       delay;
  logic [15:0]       count;
  logic [31:0]       gpio_data;
  logic              stb_q;
  logic              timeout;

  logic              wr_ctrl;
  logic              wr_delay;
  logic              wr_push;
  logic              flush;
  logic              clr_flags;
  logic              pop;
  logic              push_ok;
  logic              overflow;
  logic              start_bus;
  logic              complete;
  logic [31:0]       rd_mux;
  logic              unused;

  assign wr_ctrl   = wb.stb && wb.we && (wb.addr == 2'd0);
  assign wr_delay  = wb.stb && wb.we && (wb.addr == 2'd1);
  assign wr_push   = wb.stb && wb.we && (wb.addr == 2'd2);
  assign flush     = wr_ctrl && wb.wdata[1];
  assign clr_flags = wr_ctrl && wb.wdata[2];

  assign empty = (fill == '0);
  assign full  = fill[LGFIFO];
  assign fill4 = 4'(fill);
  assign head  = mem[rd_ptr];
  assign busy  = (state != IDLE);

  assign pop       = (state == IDLE) && run && !empty;
  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign push_ok   = wr_push && (!full || pop);
  assign overflow  = wr_push && full && !pop;
  assign start_bus = (state == WAIT) && (count == 16'd0);
  assign complete  = (state == BUS) && gpio.ack;

  always_ff @(posedge i_clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= {delay, wb.wdata};
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + LGFIFO'(1);
      if (pop)     rd_ptr <= rd_ptr + LGFIFO'(1);
      case ({push_ok, pop})
        2'b10:   fill <= fill + (LGFIFO+1)'(1);
        2'b01:   fill <= fill - (LGFIFO+1)'(1);
        default: fill <= fill;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (pop) state_nx = WAIT;
      WAIT:    if (count == 16'd0) state_nx = BUS;
      BUS:     if (gpio.ack || timeout) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      count     <= '0;
      gpio_data <= '0;
      stb_q     <= 1'b0;
    end else begin
      if (pop) begin
        count     <= head[47:32];
        gpio_data <= head[31:0];
      end else if ((state == WAIT) && (count != 16'd0)) begin
        count <= count - 16'd1;
      end

      if (start_bus) begin
        stb_q <= 1'b1;
      end else if ((state == BUS) && (!gpio.stall || gpio.ack || timeout)) begin
        stb_q <= 1'b0;
      end
    end
  end

  // Setting events win over a same-cycle clear so no event is lost.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      run   <= 1'b0;
      done  <= 1'b0;
      ovf   <= 1'b0;
      delay <= '0;
    end else begin
      if (timeout) begin
        run <= 1'b0;
      end else if (wr_ctrl) begin
        run <= wb.wdata[0];
      end

      if (complete && empty) begin
        done <= 1'b1;
      end else if (clr_flags) begin
        done <= 1'b0;
      end

      if (overflow) begin
        ovf <= 1'b1;
      end else if (clr_flags) begin
        ovf <= 1'b0;
      end

      if (wr_delay) begin
        delay <= wb.wdata[15:0];
      end
    end
  end

`ifdef GPIO_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TMO_CYCLES + 1);

  logic [TW-1:0] tmo_cnt;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      tmo_cnt <= '0;
    end else if ((state != BUS) || gpio.ack) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end
  end

  assign timeout = (state == BUS) && !gpio.ack && (tmo_cnt == TW'(TMO_CYCLES - 1));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      err <= 1'b0;
    end else if (timeout) begin
      err <= 1'b1;
    end else if (clr_flags) begin
      err <= 1'b0;
    end
  end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  always_comb begin
    rd_mux = '0;
    case (wb.addr)
      2'd0:    rd_mux = {18'b0, empty, full, fill4, 3'b0, ovf, err, done, busy, run};
      2'd1:    rd_mux = {16'b0, delay};
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wb.ack   <= 1'b0;
      wb.rdata <= '0;
    end else begin
      wb.ack   <= wb.stb;
      wb.rdata <= (wb.stb && !wb.we) ? rd_mux : '0;
    end
  end

  assign wb.stall   = 1'b0;
  assign gpio.cyc   = (state == BUS);
  assign gpio.stb   = stb_q;
  assign gpio.we    = 1'b1;
  assign gpio.addr  = '0;
  assign gpio.sel   = 4'hF;
  assign gpio.wdata = gpio_data;
  assign o_int      = done | err;

  assign unused = &{1'b0, wb.cyc, wb.sel, gpio.rdata, (TMO_CYCLES > 0)};

endmodule

`default_nettype wire

// File: tb/tb_gpio_seq.sv
// +----------------------------------------------------------------------+
// | tb_gpio_seq : scoreboard bench for gpio_seq (GPIO_SEQ_TIMEOUT_EN opt).|
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_gpio_seq;

  logic clk = 1'b0;
  logic rst;
  logic irq;

  always #5 clk = ~clk;

  gpio_seq_if #(.AW(2)) wb ();
  gpio_seq_if #(.AW(2)) gpio ();

  gpio_seq #(.LGFIFO(3), .TMO_CYCLES(16)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .wb      (wb),
    .gpio    (gpio),
    .o_int   (irq)
  );

  int          checks;
  int          errors;
  int          cyc_cnt = 0;
  logic [31:0] sb_q[$];
  logic [31:0] obs_q[$];

  bit resp_en;
  int stall_left;
  int ack_lag;
  int first_stb = 0;
  int stb_run = 0;
  int last_stb_len = 0;
  bit stb_prev = 0;
  bit cyc_at_fall = 0;

  initial forever begin
    @(posedge clk);
    cyc_cnt++;
  end

  // GPIO slave model: stalls, accepts and acks; records accepted words.
  initial begin
    int  lag_left;
    bit  pending;
    lag_left   = 0;
    pending    = 0;
    gpio.ack   = 1'b0;
    gpio.stall = 1'b0;
    gpio.rdata = '0;
    forever begin
      @(negedge clk);
      if (gpio.stb && !stb_prev) begin
        first_stb = cyc_cnt;
        stb_run   = 1;
      end else if (gpio.stb) begin
        stb_run++;
      end
      if (!gpio.stb && stb_prev) begin
        last_stb_len = stb_run;
        cyc_at_fall  = gpio.cyc;
      end
      stb_prev = gpio.stb;

      gpio.ack   = 1'b0;
      gpio.stall = 1'b0;
      if (!gpio.cyc) begin
        pending = 0;
      end else if (resp_en) begin
        if (gpio.stb) begin
          if (stall_left > 0) begin
            gpio.stall = 1'b1;
            stall_left--;
          end else begin
            obs_q.push_back(gpio.wdata);
            if (ack_lag == 0) begin
              gpio.ack = 1'b1;
            end else begin
              pending  = 1;
              lag_left = ack_lag;
            end
          end
        end else if (pending) begin
          lag_left--;
          if (lag_left <= 0) begin
            gpio.ack = 1'b1;
            pending  = 0;
          end
        end
      end
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time bound expired");
    $fatal(1);
  end

  task automatic wb_write(input logic [1:0] a, input logic [31:0] d);
    wb.cyc = 1'b1; wb.stb = 1'b1; wb.we = 1'b1; wb.addr = a; wb.wdata = d;
    @(negedge clk);
    wb.cyc = 1'b0; wb.stb = 1'b0; wb.we = 1'b0;
  endtask

  task automatic wb_read(input logic [1:0] a, output logic [31:0] d);
    wb.cyc = 1'b1; wb.stb = 1'b1; wb.we = 1'b0; wb.addr = a;
    @(negedge clk);
    wb.cyc = 1'b0; wb.stb = 1'b0;
    d = wb.rdata;
  endtask

  task automatic wait_obs(output bit ok);
    for (int i = 0; i < 300 && obs_q.size() == 0; i++) @(negedge clk);
    ok = (obs_q.size() != 0);
  endtask

  task automatic wait_idle(output bit ok);
    logic [31:0] d;
    ok = 0;
    for (int i = 0; i < 150; i++) begin
      wb_read(2'd0, d);
      if (d[1] == 1'b0) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (gpio.cyc !== 1'b0 || gpio.stb !== 1'b0) begin
      errors++; $display("FAIL reset_gpio_strobes: cyc=%b stb=%b, expected 0 0", gpio.cyc, gpio.stb);
    end
    checks++;
    if (gpio.wdata !== 32'h0) begin
      errors++; $display("FAIL reset_gpio_data: got %h, expected 0", gpio.wdata);
    end
    checks++;
    if (wb.ack !== 1'b0 || wb.rdata !== 32'h0) begin
      errors++; $display("FAIL reset_wb: ack=%b data=%h, expected 0 0", wb.ack, wb.rdata);
    end
    checks++;
    if (irq !== 1'b0) begin
      errors++; $display("FAIL reset_int: got %b, expected 0", irq);
    end
    rst = 1'b0;
    @(negedge clk);
    wb_read(2'd0, d);
    checks++;
    if (d !== 32'h0000_2000) begin
      errors++; $display("FAIL reset_ctrl: got %h, expected 00002000", d);
    end
    wb_read(2'd1, d);
    checks++;
    if (d !== 32'h0) begin
      errors++; $display("FAIL reset_delay: got %h, expected 0", d);
    end
  endtask

  task automatic test_slave_ack();
    logic [31:0] d;
    wb.cyc = 1'b1; wb.stb = 1'b1; wb.we = 1'b0; wb.addr = 2'd3;
    @(negedge clk);
    wb.cyc = 1'b0; wb.stb = 1'b0;
    checks++;
    if (wb.ack !== 1'b1 || wb.rdata !== 32'h0) begin
      errors++; $display("FAIL ack_reserved: ack=%b data=%h, expected 1 0", wb.ack, wb.rdata);
    end
    @(negedge clk);
    checks++;
    if (wb.ack !== 1'b0) begin
      errors++; $display("FAIL ack_single: ack=%b, expected 0", wb.ack);
    end
    wb_write(2'd1, 32'h1234_ABCD);
    wb_read(2'd1, d);
    checks++;
    if (d !== 32'h0000_ABCD) begin
      errors++; $display("FAIL delay_readback: got %h, expected 0000abcd", d);
    end
  endtask

  task automatic test_delay_latency();
    int          t0;
    bit          ok;
    logic [31:0] d;
    logic [31:0] got;
    logic [31:0] exp_w;
    wb_write(2'd1, 32'd5);
    wb_write(2'd2, 32'h0001_0001);
    sb_q.push_back(32'h0001_0001);
    wb_write(2'd0, 32'h1);
    t0 = cyc_cnt;
    wait_obs(ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL latency_write: no gpio write seen, expected 00010001");
    end else begin
      got = obs_q.pop_front(); exp_w = sb_q.pop_front();
      if (got !== exp_w) begin
        errors++; $display("FAIL latency_write: got %h, expected %h", got, exp_w);
      end
    end
    checks++;
    if (first_stb - t0 !== 7) begin
      errors++; $display("FAIL latency_cycles: stb after %0d cycles from run edge, expected 7", first_stb - t0);
    end
    wait_idle(ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL latency_idle: BUSY stuck at 1, expected 0");
    end
    wb_read(2'd0, d);
    checks++;
    if (d !== 32'h0000_2005 || irq !== 1'b1) begin
      errors++; $display("FAIL latency_done: ctrl=%h int=%b, expected 00002005 1", d, irq);
    end
    wb_write(2'd0, 32'h4);
    checks++;
    if (irq !== 1'b0) begin
      errors++; $display("FAIL done_clear: int=%b, expected 0", irq);
    end
  endtask

  task automatic test_overflow();
    bit          ok;
    logic [31:0] d;
    logic [31:0] got;
    logic [31:0] exp_w;
    wb_write(2'd1, 32'd0);
    for (int i = 0; i < 9; i++) begin
      wb_write(2'd2, 32'hA5A5_0000 + i);
      if (i < 8) sb_q.push_back(32'hA5A5_0000 + i);
    end
    wb_read(2'd0, d);
    checks++;
    if (d !== 32'h0000_1810) begin
      errors++; $display("FAIL overflow_ctrl: got %h, expected 00001810", d);
    end
    wb_write(2'd0, 32'h1);
    for (int i = 0; i < 8; i++) begin
      wait_obs(ok);
      checks++;
      if (!ok) begin
        errors++; $display("FAIL overflow_drain: word %0d missing, expected %h", i, sb_q[0]);
        break;
      end
      got = obs_q.pop_front(); exp_w = sb_q.pop_front();
      if (got !== exp_w) begin
        errors++; $display("FAIL overflow_drain: word %0d got %h, expected %h", i, got, exp_w);
      end
    end
    wait_idle(ok);
    repeat (10) @(negedge clk);
    checks++;
    if (!ok || obs_q.size() != 0) begin
      errors++; $display("FAIL overflow_extra: idle=%b extra writes=%0d, expected 1 0", ok, obs_q.size());
    end
    wb_read(2'd0, d);
    checks++;
    if (d !== 32'h0000_2015) begin
      errors++; $display("FAIL overflow_final: got %h, expected 00002015", d);
    end
    wb_write(2'd0, 32'h4);
    sb_q.delete();
    obs_q.delete();
  endtask

  task automatic test_back_to_back();
    bit          ok;
    logic [31:0] d;
    logic [31:0] got;
    logic [31:0] exp_w;
    wb_write(2'd1, 32'd2);
    for (int i = 0; i < 8; i++) begin
      wb_write(2'd2, 32'h3C00_0010 + i);
      sb_q.push_back(32'h3C00_0010 + i);
    end
    wb_write(2'd0, 32'h1);
    wb_write(2'd2, 32'h3C00_0099);
    sb_q.push_back(32'h3C00_0099);
    wb_read(2'd0, d);
    checks++;
    if (d !== 32'h0000_1803) begin
      errors++; $display("FAIL push_pop_full: ctrl=%h, expected 00001803", d);
    end
    for (int i = 0; i < 9; i++) begin
      wait_obs(ok);
      checks++;
      if (!ok) begin
        errors++; $display("FAIL b2b_drain: word %0d missing, expected %h", i, sb_q[0]);
        break;
      end
      got = obs_q.pop_front(); exp_w = sb_q.pop_front();
      if (got !== exp_w) begin
        errors++; $display("FAIL b2b_drain: word %0d got %h, expected %h", i, got, exp_w);
      end
    end
    wait_idle(ok);
    wb_read(2'd0, d);
    checks++;
    if (!ok || d !== 32'h0000_2005) begin
      errors++; $display("FAIL b2b_final: idle=%b ctrl=%h, expected 1 00002005", ok, d);
    end
    wb_write(2'd0, 32'h4);
    sb_q.delete();
    obs_q.delete();
  endtask

  task automatic test_stall();
    bit          ok;
    logic [31:0] d;
    logic [31:0] got;
    logic [31:0] exp_w;
    wb_write(2'd1, 32'd0);
    stall_left = 3;
    ack_lag    = 2;
    wb_write(2'd2, 32'hF0F0_5A5A);
    sb_q.push_back(32'hF0F0_5A5A);
    wb_write(2'd0, 32'h1);
    wait_obs(ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL stall_write: no gpio write seen, expected f0f05a5a");
    end else begin
      got = obs_q.pop_front(); exp_w = sb_q.pop_front();
      if (got !== exp_w) begin
        errors++; $display("FAIL stall_write: got %h, expected %h", got, exp_w);
      end
    end
    wait_idle(ok);
    checks++;
    if (last_stb_len !== 4) begin
      errors++; $display("FAIL stall_stb_len: stb high %0d cycles, expected 4", last_stb_len);
    end
    checks++;
    if (cyc_at_fall !== 1'b1) begin
      errors++; $display("FAIL stall_cyc_hold: cyc=%b when stb fell, expected 1", cyc_at_fall);
    end
    wb_read(2'd0, d);
    checks++;
    if (!ok || obs_q.size() != 0 || d !== 32'h0000_2005) begin
      errors++; $display("FAIL stall_final: idle=%b extra=%0d ctrl=%h, expected 1 0 00002005", ok, obs_q.size(), d);
    end
    wb_write(2'd0, 32'h4);
    stall_left = 0;
    ack_lag    = 0;
  endtask

  task automatic test_run_clear();
    bit          ok;
    logic [31:0] d;
    logic [31:0] got;
    logic [31:0] exp_w;
    wb_write(2'd1, 32'd20);
    wb_write(2'd2, 32'h0101_0001);
    sb_q.push_back(32'h0101_0001);
    wb_write(2'd2, 32'h0202_0002);
    wb_write(2'd2, 32'h0404_0004);
    wb_write(2'd0, 32'h1);
    repeat (5) @(negedge clk);
    wb_write(2'd0, 32'h0);
    wait_obs(ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL runclr_write: in-flight write missing, expected 01010001");
    end else begin
      got = obs_q.pop_front(); exp_w = sb_q.pop_front();
      if (got !== exp_w) begin
        errors++; $display("FAIL runclr_write: got %h, expected %h", got, exp_w);
      end
    end
    wait_idle(ok);
    repeat (40) @(negedge clk);
    wb_read(2'd0, d);
    checks++;
    if (!ok || d !== 32'h0000_0200) begin
      errors++; $display("FAIL runclr_ctrl: idle=%b ctrl=%h, expected 1 00000200", ok, d);
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++; $display("FAIL runclr_nopop: %0d extra writes, expected 0", obs_q.size());
    end
    wb_write(2'd0, 32'h2);
    wb_read(2'd0, d);
    checks++;
    if (d !== 32'h0000_2000) begin
      errors++; $display("FAIL flush_ctrl: got %h, expected 00002000", d);
    end
    sb_q.delete();
    obs_q.delete();
  endtask

`ifdef GPIO_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    logic [31:0] d;
    int          n;
    resp_en = 0;
    wb_write(2'd1, 32'd0);
    wb_write(2'd2, 32'h7777_0007);
    wb_write(2'd0, 32'h1);
    n = 0;
    for (int i = 0; i < 50 && gpio.cyc !== 1'b1; i++) @(negedge clk);
    for (int i = 0; i < 100 && gpio.cyc === 1'b1; i++) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n !== 16) begin
      errors++; $display("FAIL timeout_len: cyc high %0d cycles, expected 16", n);
    end
    wb_read(2'd0, d);
    checks++;
    if (d !== 32'h0000_2008 || irq !== 1'b1) begin
      errors++; $display("FAIL timeout_ctrl: ctrl=%h int=%b, expected 00002008 1", d, irq);
    end
    wb_write(2'd0, 32'h4);
    checks++;
    if (irq !== 1'b0) begin
      errors++; $display("FAIL timeout_clear: int=%b, expected 0", irq);
    end
    resp_en = 1;
    obs_q.delete();
  endtask
`endif

  task automatic test_reset_mid_bus();
    logic [31:0] d;
    resp_en = 0;
    wb_write(2'd1, 32'd1);
    wb_write(2'd2, 32'h5555_AAAA);
    wb_write(2'd2, 32'h6666_BBBB);
    wb_write(2'd0, 32'h1);
    for (int i = 0; i < 50 && gpio.cyc !== 1'b1; i++) @(negedge clk);
    checks++;
    if (gpio.cyc !== 1'b1) begin
      errors++; $display("FAIL midbus_reach: cyc=%b, expected 1", gpio.cyc);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (gpio.cyc !== 1'b0 || gpio.stb !== 1'b0) begin
      errors++; $display("FAIL midbus_async: cyc=%b stb=%b, expected 0 0", gpio.cyc, gpio.stb);
    end
    @(negedge clk);
    rst = 1'b0;
    resp_en = 1;
    @(negedge clk);
    wb_read(2'd0, d);
    checks++;
    if (d !== 32'h0000_2000 || irq !== 1'b0) begin
      errors++; $display("FAIL midbus_ctrl: ctrl=%h int=%b, expected 00002000 0", d, irq);
    end
    wb_read(2'd1, d);
    checks++;
    if (d !== 32'h0) begin
      errors++; $display("FAIL midbus_delay: got %h, expected 0", d);
    end
    obs_q.delete();
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    resp_en    = 1;
    stall_left = 0;
    ack_lag    = 0;
    rst        = 1'b1;
    wb.cyc = 1'b0; wb.stb = 1'b0; wb.we = 1'b0;
    wb.addr = 2'd0; wb.wdata = 32'h0; wb.sel = 4'hF;
    @(negedge clk);
    test_reset();
    test_slave_ack();
    test_delay_latency();
    test_overflow();
    test_back_to_back();
    test_stall();
    test_run_clear();
`ifdef GPIO_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_bus();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
